cart_bus_master: RTL and testbench



---
 rtl/cart_bus_pkg.sv | 49 ++++
 rtl/cart_bus_timer.sv | 27 ++
 rtl/cart_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_cart_bus_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types, address map constants and header-probe helpers for the cartridge bus master.
package cart_bus_pkg;

  typedef enum logic [2:0] {
    ST_PROBE,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM
  } region_t;

  localparam int unsigned ADR_W  = 16;
  localparam int unsigned CADR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned ROM_HI_BIT = 15;
  localparam logic [2:0]  RAM_TAG    = 3'b101;

  localparam logic [ADR_W-1:0] HDR_MBC_ADR = 16'h0147;
  localparam logic [ADR_W-1:0] HDR_ROM_ADR = 16'h0148;
  localparam logic [ADR_W-1:0] HDR_RAM_ADR = 16'h0149;

  localparam logic [DATA_W-1:0] ROM_CODE_MAX = 8'd6;
  localparam logic [DATA_W-1:0] RAM_CODE_MAX = 8'd3;

  // Classify a CPU address into the chip select it needs, if any.
  function automatic region_t decode_region(input logic [ADR_W-1:0] adr);
    if (adr[ROM_HI_BIT] == 1'b0) return REG_ROM;
    if (adr[15:13] == RAM_TAG)   return REG_RAM;
    return REG_NONE;
  endfunction

  // Cartridge address of the idx-th header byte read during the probe.
  function automatic logic [CADR_W-1:0] hdr_cadr(input logic [1:0] idx);
    case (idx)
      2'd0:    return HDR_MBC_ADR[CADR_W-1:0];
      2'd1:    return HDR_ROM_ADR[CADR_W-1:0];
      default: return HDR_RAM_ADR[CADR_W-1:0];
    endcase
  endfunction

endpackage

// File: rtl/cart_bus_timer.sv
// Phase-length down-counter; last_c flags the final cycle of the loaded phase.
module cart_bus_timer
  import cart_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             last_c
);

  logic [CNT_W-1:0] count;

  // Load len-1 on phase entry, then count down to zero and park there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= len - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last_c = (count == '0);

endmodule

// File: rtl/cart_bus_master.sv
// Cartridge bus initiator: header probe after reset, then timed single-beat CPU cycles.
module cart_bus_master
  import cart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [14:0] cadr,
  output logic [7:0]  cdata_out,
  output logic        cdata_oe,
  input  logic [7:0]  cdata_in,
  output logic        cwrite,
  output logic        ccs_rom,
  output logic        ccs_ram,
  output logic        hdr_valid,
  output logic [7:0]  mbc_type,
  output logic [2:0]  rom_size,
  output logic [1:0]  ram_size,
  output logic        hdr_error
);

  localparam logic [CNT_W-1:0] SETUP_LEN  = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LEN = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LEN   = CNT_W'(HOLD_CYCLES);

  state_t           state;
  logic             we_q;
  logic             probing;
  logic [1:0]       probe_idx;
  region_t          req_region_c;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_len_c;
  logic             tmr_last_c;

  assign req_region_c = decode_region(req_adr);

  cart_bus_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load_c),
    .len     (tmr_len_c),
    .last_c  (tmr_last_c)
  );

  // Start the timer on every phase entry with that phase's length.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_len_c  = SETUP_LEN;
    case (state)
      ST_PROBE:  tmr_load_c = 1'b1;
      ST_IDLE:   tmr_load_c = req && req_ready && (req_region_c != REG_NONE);
      ST_SETUP: begin
        tmr_load_c = tmr_last_c;
        tmr_len_c  = STROBE_LEN;
      end
      ST_STROBE: begin
        tmr_load_c = tmr_last_c;
        tmr_len_c  = HOLD_LEN;
      end
      ST_HOLD:   tmr_load_c = tmr_last_c && probing && (probe_idx != 2'd2);
      default:   tmr_load_c = 1'b0;
    endcase
  end

  // Bus cycle sequencer with registered strobes, selects and responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_PROBE;
      we_q      <= 1'b0;
      probing   <= 1'b1;
      probe_idx <= 2'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cadr      <= '0;
      cdata_out <= '0;
      cdata_oe  <= 1'b0;
      cwrite    <= 1'b0;
      ccs_rom   <= 1'b0;
      ccs_ram   <= 1'b0;
      hdr_valid <= 1'b0;
      mbc_type  <= '0;
      rom_size  <= '0;
      ram_size  <= '0;
      hdr_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_PROBE: begin
          probing   <= 1'b1;
          probe_idx <= 2'd0;
          we_q      <= 1'b0;
          cadr      <= hdr_cadr(2'd0);
          ccs_rom   <= 1'b1;
          state     <= ST_SETUP;
        end
        ST_IDLE: begin
          if (req && req_ready) begin
            case (req_region_c)
              REG_ROM, REG_RAM: begin
                we_q      <= req_we;
                cadr      <= req_adr[14:0];
                ccs_rom   <= (req_region_c == REG_ROM);
                ccs_ram   <= (req_region_c == REG_RAM);
                cdata_oe  <= req_we;
                if (req_we) cdata_out <= req_wdata;
                req_ready <= 1'b0;
                state     <= ST_SETUP;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end
        ST_SETUP: begin
          if (tmr_last_c) begin
            cwrite <= we_q;
            state  <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tmr_last_c) begin
            cwrite <= 1'b0;
            state  <= ST_HOLD;
            if (!we_q && !probing) begin
              rsp_rdata <= cdata_in;
            end else if (!we_q) begin
              case (probe_idx)
                2'd0: mbc_type <= cdata_in;
                2'd1: begin
                  if (cdata_in <= ROM_CODE_MAX) begin
                    rom_size <= cdata_in[2:0];
                  end else begin
                    rom_size  <= '0;
                    hdr_error <= 1'b1;
                  end
                end
                default: begin
                  if (cdata_in <= RAM_CODE_MAX) begin
                    ram_size <= cdata_in[1:0];
                  end else begin
                    ram_size  <= '0;
                    hdr_error <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
        ST_HOLD: begin
          if (tmr_last_c) begin
            if (probing && (probe_idx != 2'd2)) begin
              probe_idx <= probe_idx + 2'd1;
              cadr      <= hdr_cadr(probe_idx + 2'd1);
              state     <= ST_SETUP;
            end else begin
              ccs_rom   <= 1'b0;
              ccs_ram   <= 1'b0;
              cdata_oe  <= 1'b0;
              req_ready <= 1'b1;
              state     <= ST_IDLE;
              if (probing) begin
                probing   <= 1'b0;
                hdr_valid <= 1'b1;
              end else begin
                rsp_valid <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_master.sv
// Self-checking bench: cartridge ROM/RAM/MBC1 model plus a transaction-level reference model.
module tb_cart_bus_master;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 1;
  localparam int BUS_LAT   = S + T + H + 1;
  localparam int PROBE_LAT = 3 * (S + T + H) + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        req_we;
  logic [15:0] req_adr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [14:0] cadr;
  logic [7:0]  cdata_out;
  logic        cdata_oe;
  logic [7:0]  cdata_in;
  logic        cwrite;
  logic        ccs_rom;
  logic        ccs_ram;
  logic        hdr_valid;
  logic [7:0]  mbc_type;
  logic [2:0]  rom_size;
  logic [1:0]  ram_size;
  logic        hdr_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] hdr [3];
  logic [7:0] cart_ram [8192];
  logic [7:0] exp_ram  [8192];
  logic [4:0] mbc_bank;
  logic       mbc_ram_en;
  logic [4:0] exp_bank;
  logic       exp_ram_en;
  logic       prev_cw;

  cart_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cadr(cadr), .cdata_out(cdata_out),
    .cdata_oe(cdata_oe), .cdata_in(cdata_in), .cwrite(cwrite), .ccs_rom(ccs_rom),
    .ccs_ram(ccs_ram), .hdr_valid(hdr_valid), .mbc_type(mbc_type), .rom_size(rom_size),
    .ram_size(ram_size), .hdr_error(hdr_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    if (a == 15'h0147) return hdr[0];
    if (a == 15'h0148) return hdr[1];
    if (a == 15'h0149) return hdr[2];
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3c;
  endfunction

  // Cartridge read data as presented by ROM or RAM.
  always_comb begin
    cdata_in = 8'hff;
    if (ccs_ram)      cdata_in = cart_ram[cadr[12:0]];
    else if (ccs_rom) cdata_in = rom_byte(cadr);
  end

  // Responder side: commit on the falling edge of cwrite while still selected.
  always @(posedge clk) begin
    prev_cw <= cwrite;
    if (prev_cw && !cwrite) begin
      if (ccs_ram) cart_ram[cadr[12:0]] <= cdata_out;
      if (ccs_rom) begin
        if (cadr < 15'h2000)      mbc_ram_en <= (cdata_out[3:0] == 4'ha);
        else if (cadr < 15'h4000) mbc_bank   <= (cdata_out[4:0] == 5'd0) ? 5'd1 : cdata_out[4:0];
      end
    end
  end

  // Bus invariants every cycle outside reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (ccs_rom && ccs_ram) begin
        failures++;
        $display("FAIL cs_exclusive: ccs_rom=%0b ccs_ram=%0b required not both", ccs_rom, ccs_ram);
      end
      checks++;
      if (cwrite && !(ccs_rom || ccs_ram)) begin
        failures++;
        $display("FAIL cwrite_needs_cs: cwrite=1 with no chip select");
      end
    end
  end

  task automatic run_txn(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                         output logic [7:0] rd, output logic er, output int lat,
                         output int rom_c, output int ram_c, output int wr_c,
                         output int gap, output bit stable, output int waited);
    int cyc = 0;
    int last_cs = 0;
    int last_wr = 0;
    rd = 'x; er = 'x; lat = -1; rom_c = 0; ram_c = 0; wr_c = 0; gap = -1; stable = 1'b1;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) return;
    req = 1'b1; req_we = we; req_adr = adr; req_wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      req_adr = 16'($urandom); req_wdata = 8'($urandom); req_we = 1'($urandom);
      if (ccs_rom) rom_c++;
      if (ccs_ram) ram_c++;
      if (cwrite) begin wr_c++; last_wr = cyc; end
      if (ccs_rom || ccs_ram) begin
        last_cs = cyc;
        if (cadr !== adr[14:0]) stable = 1'b0;
        if (we && (cdata_oe !== 1'b1 || cdata_out !== wd)) stable = 1'b0;
        if (!we && cdata_oe !== 1'b0) stable = 1'b0;
      end
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; lat = cyc;
        break;
      end
    end
    if (wr_c > 0) gap = last_cs - last_wr;
  endtask

  task automatic run_probe(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           output int cyc, output bit ready_seen, output bit rsp_seen);
    hdr[0] = b0; hdr[1] = b1; hdr[2] = b2;
    ready_seen = 1'b0; rsp_seen = 1'b0; cyc = 0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    while (!hdr_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (req_ready && !hdr_valid) ready_seen = 1'b1;
      if (rsp_valid) rsp_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [52:0] v;
    reset_n = 1'b0;
    #1;
    v = {req_ready, rsp_valid, rsp_err, cdata_oe, cwrite, ccs_rom, ccs_ram, hdr_valid,
         hdr_error, rsp_rdata, mbc_type, rom_size, ram_size, cadr, cdata_out};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", v);
    end
  endtask

  task automatic test_probe_good();
    int cyc; bit rs; bit vs;
    run_probe(8'h01, 8'h03, 8'h02, cyc, rs, vs);
    checks++;
    if (cyc != PROBE_LAT) begin failures++; $display("FAIL probe_latency: got %0d required %0d", cyc, PROBE_LAT); end
    checks++;
    if ({rs, vs} !== 2'b00) begin failures++; $display("FAIL probe_ready_rsp: ready/rsp seen %b required 00", {rs, vs}); end
    checks++;
    if ({hdr_valid, mbc_type, rom_size, ram_size, hdr_error} !== {1'b1, 8'h01, 3'd3, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL probe_good: valid=%0b mbc=%h rom=%0d ram=%0d err=%0b required 1/01/3/2/0",
               hdr_valid, mbc_type, rom_size, ram_size, hdr_error);
    end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL probe_ready_after: got %0b required 1", req_ready); end
  endtask

  task automatic test_probe_bad_rom();
    int cyc; bit rs; bit vs;
    run_probe(8'h01, 8'h09, 8'h02, cyc, rs, vs);
    checks++;
    if ({hdr_valid, rom_size, ram_size, hdr_error} !== {1'b1, 3'd0, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL probe_bad_rom: valid=%0b rom=%0d ram=%0d err=%0b required 1/0/2/1",
               hdr_valid, rom_size, ram_size, hdr_error);
    end
  endtask

  task automatic test_probe_random();
    int cyc; bit rs; bit vs;
    logic [7:0] m, r, a;
    logic [2:0] er_rom; logic [1:0] er_ram; logic ee;
    for (int i = 0; i < 5; i++) begin
      m = 8'($urandom);
      r = 8'($urandom_range(0, 9));
      a = 8'($urandom_range(0, 5));
      er_rom = (r > 6) ? 3'd0 : r[2:0];
      er_ram = (a > 3) ? 2'd0 : a[1:0];
      ee     = (r > 6) || (a > 3);
      run_probe(m, r, a, cyc, rs, vs);
      checks++;
      if ({cyc == PROBE_LAT, hdr_valid, mbc_type, rom_size, ram_size, hdr_error} !==
          {1'b1, 1'b1, m, er_rom, er_ram, ee}) begin
        failures++;
        $display("FAIL probe_rand[%0d]: cyc=%0d mbc=%h rom=%0d ram=%0d err=%0b required %0d/%h/%0d/%0d/%0b",
                 i, cyc, mbc_type, rom_size, ram_size, hdr_error, PROBE_LAT, m, er_rom, er_ram, ee);
      end
    end
    run_probe(8'h01, 8'h03, 8'h02, cyc, rs, vs);
  endtask

  task automatic test_write_rom();
    logic [7:0] rd; logic er; int lat, rc, mc, wc, gap, w; bit st;
    run_txn(1'b1, 16'h2000, 8'h05, rd, er, lat, rc, mc, wc, gap, st, w);
    exp_bank = 5'd5;
    @(negedge clk);
    checks++;
    if ({lat, rc, mc, wc, gap} !== {BUS_LAT, S + T + H, 0, T, H}) begin
      failures++;
      $display("FAIL write_rom_timing: lat=%0d rom_cs=%0d ram_cs=%0d cwrite=%0d hold=%0d required %0d/%0d/0/%0d/%0d",
               lat, rc, mc, wc, gap, BUS_LAT, S + T + H, T, H);
    end
    checks++;
    if ({st, er} !== 2'b10) begin failures++; $display("FAIL write_rom_stable_err: got %b required 10", {st, er}); end
    checks++;
    if (mbc_bank !== exp_bank) begin failures++; $display("FAIL write_rom_bank: got %0d required %0d", mbc_bank, exp_bank); end
  endtask

  task automatic test_read_ram();
    logic [7:0] rd; logic er; int lat, rc, mc, wc, gap, w; bit st;
    cart_ram[13'h0010] = 8'h5a; exp_ram[13'h0010] = 8'h5a;
    run_txn(1'b0, 16'ha010, 8'h00, rd, er, lat, rc, mc, wc, gap, st, w);
    checks++;
    if ({rd, er, lat, rc, mc, wc, st} !== {8'h5a, 1'b0, BUS_LAT, 0, S + T + H, 0, 1'b1}) begin
      failures++;
      $display("FAIL read_ram: rd=%h err=%0b lat=%0d rom_cs=%0d ram_cs=%0d wr=%0d stable=%0b required 5a/0/%0d/0/%0d/0/1",
               rd, er, lat, rc, mc, wc, st, BUS_LAT, S + T + H);
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] rd; logic er; int lat, rc, mc, wc, gap, w; bit st;
    run_txn(1'b0, 16'hc000, 8'h00, rd, er, lat, rc, mc, wc, gap, st, w);
    checks++;
    if ({er, lat, rc, mc} !== {1'b1, 1, 0, 0}) begin
      failures++;
      $display("FAIL unmapped: err=%0b lat=%0d rom_cs=%0d ram_cs=%0d required 1/1/0/0", er, lat, rc, mc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int lat, rc, mc, wc, gap, w; bit st;
    run_txn(1'b0, 16'h0100, 8'h00, rd, er, lat, rc, mc, wc, gap, st, w);
    run_txn(1'b0, 16'ha020, 8'h00, rd, er, lat, rc, mc, wc, gap, st, w);
    checks++;
    if ({w, lat, rd, er} !== {0, BUS_LAT, exp_ram[13'h0020], 1'b0}) begin
      failures++;
      $display("FAIL back_to_back: wait=%0d lat=%0d rd=%h err=%0b required 0/%0d/%h/0",
               w, lat, rd, er, BUS_LAT, exp_ram[13'h0020]);
    end
    run_txn(1'b0, 16'h9000, 8'h00, rd, er, lat, rc, mc, wc, gap, st, w);
    run_txn(1'b0, 16'h0155, 8'h00, rd, er, lat, rc, mc, wc, gap, st, w);
    checks++;
    if ({w, lat, rd} !== {0, BUS_LAT, rom_byte(15'h0155)}) begin
      failures++;
      $display("FAIL err_then_read: wait=%0d lat=%0d rd=%h required 0/%0d/%h", w, lat, rd, BUS_LAT, rom_byte(15'h0155));
    end
  endtask

  task automatic test_reset_abort();
    int n = 0; int cyc = 0;
    req = 1'b1; req_we = 1'b1; req_adr = 16'h0000; req_wdata = 8'h0a;
    @(posedge clk);
    #1 req = 1'b0;
    while (!cwrite && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cwrite !== 1'b1) begin failures++; $display("FAIL abort_reach_strobe: cwrite=%0b required 1", cwrite); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ccs_rom, ccs_ram, cwrite, cdata_oe, req_ready, hdr_valid} !== 6'b0) begin
      failures++;
      $display("FAIL abort_drop: cs_rom/cs_ram/cwrite/oe/ready/hv=%b required 000000",
               {ccs_rom, ccs_ram, cwrite, cdata_oe, req_ready, hdr_valid});
    end
    @(negedge clk); reset_n = 1'b1;
    while (!hdr_valid && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if ({cyc == PROBE_LAT, mbc_ram_en} !== {1'b1, exp_ram_en}) begin
      failures++;
      $display("FAIL abort_recover: probe_cyc=%0d ram_en=%0b required %0d/%0b", cyc, mbc_ram_en, PROBE_LAT, exp_ram_en);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd; logic er; int lat, rc, mc, wc, gap, w; bit st;
    logic we; logic [15:0] adr; logic [7:0] wd; int kind;
    logic [7:0] e_rd; logic e_er; int e_lat, e_rc, e_mc;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      we   = 1'($urandom);
      wd   = 8'($urandom);
      case (kind)
        0:       adr = we ? 16'($urandom_range(0, 16'h3fff)) : 16'($urandom_range(0, 16'h7fff));
        1:       adr = 16'($urandom_range(16'ha000, 16'hbfff));
        default: adr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h8000, 16'h9fff))
                                                  : 16'($urandom_range(16'hc000, 16'hffff));
      endcase
      e_er = 1'b0; e_rd = 'x; e_lat = BUS_LAT; e_rc = 0; e_mc = 0;
      if (adr < 16'h8000) begin
        e_rc = S + T + H;
        if (we) begin
          if (adr < 16'h2000)      exp_ram_en = (wd[3:0] == 4'ha);
          else if (adr < 16'h4000) exp_bank   = (wd[4:0] == 5'd0) ? 5'd1 : wd[4:0];
        end else e_rd = rom_byte(adr[14:0]);
      end else if (adr >= 16'ha000 && adr < 16'hc000) begin
        e_mc = S + T + H;
        if (we) exp_ram[adr - 16'ha000] = wd;
        else    e_rd = exp_ram[adr - 16'ha000];
      end else begin
        e_er = 1'b1; e_lat = 1;
      end
      run_txn(we, adr, wd, rd, er, lat, rc, mc, wc, gap, st, w);
      checks++;
      if ({er, lat, rc, mc, st} !== {e_er, e_lat, e_rc, e_mc, 1'b1} ||
          (!we && !e_er && rd !== e_rd) || (we && !e_er && (wc != T || gap != H))) begin
        failures++;
        $display("FAIL random[%0d] we=%0b adr=%h: rd=%h err=%0b lat=%0d rom=%0d ram=%0d wr=%0d hold=%0d st=%0b required rd=%h err=%0b lat=%0d rom=%0d ram=%0d",
                 i, we, adr, rd, er, lat, rc, mc, wc, gap, st, e_rd, e_er, e_lat, e_rc, e_mc);
      end
    end
    @(negedge clk);
    checks++;
    if ({mbc_bank, mbc_ram_en} !== {exp_bank, exp_ram_en}) begin
      failures++;
      $display("FAIL random_mbc: bank=%0d ram_en=%0b required %0d/%0b", mbc_bank, mbc_ram_en, exp_bank, exp_ram_en);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
    mbc_bank = 5'd1; mbc_ram_en = 1'b0; exp_bank = 5'd1; exp_ram_en = 1'b0; prev_cw = 1'b0;
    hdr[0] = 8'h01; hdr[1] = 8'h03; hdr[2] = 8'h02;
    for (int i = 0; i < 8192; i++) begin
      cart_ram[i] = 8'($urandom);
      exp_ram[i]  = cart_ram[i];
    end
    test_reset();
    test_probe_good();
    test_probe_bad_rom();
    test_probe_random();
    test_write_rom();
    test_read_ram();
    test_unmapped();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
